rr_input_arbiter: RTL and testbench

//  Round-robin arbiter sharing a router's single forwarding path between its input FIFOs
//  (index 0=NI, 1=NORTH, 2=SOUTH, 3=EAST, 4=WEST).

---
 rtl/rr_input_arbiter_if.sv | 27 ++
 rtl/rr_input_arbiter.sv | 94 +++++++++
 tb/tb_rr_input_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rr_input_arbiter_if.sv
// Handshake bundle between the router input FIFOs, the round-robin arbiter and the route stage.
// The master modport is the arbiter's view; slave is the FIFO/route-stage side.
interface rr_input_arbiter_if #(
  parameter int NUM_INPUTS   = 5,
  parameter int PACKET_WIDTH = 16
);
  localparam int GIDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS-1:0]                   i_fifoHasPacket;
  logic [NUM_INPUTS-1:0][PACKET_WIDTH-1:0] i_fifoReadData;
  logic                                    i_arbiterReady;
  logic [NUM_INPUTS-1:0]                   o_fifoReadEn;
  logic [PACKET_WIDTH-1:0]                 o_packet;
  logic                                    o_packetIsValid;
  logic [GIDX_W-1:0]                       o_grantIdx;
  logic                                    o_stalled;

  modport master (
    input  i_fifoHasPacket, i_fifoReadData, i_arbiterReady,
    output o_fifoReadEn, o_packet, o_packetIsValid, o_grantIdx, o_stalled
  );

  modport slave (
    output i_fifoHasPacket, i_fifoReadData, i_arbiterReady,
    input  o_fifoReadEn, o_packet, o_packetIsValid, o_grantIdx, o_stalled
  );
endinterface

// File: rtl/rr_input_arbiter.sv
// Round-robin arbiter: pops one non-empty input FIFO per grant into a holding register
// and presents it until the route stage forwards it; flags holds that last too long.
module rr_input_arbiter #(
  parameter int NUM_INPUTS   = 5,
  parameter int PACKET_WIDTH = 16,
  parameter int STALL_LIMIT  = 64
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  rr_input_arbiter_if.master   bus
);
  localparam int GIDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CNT_W  = $clog2(STALL_LIMIT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state, stateNext;
  logic [GIDX_W-1:0]       lastGrant, winner, cand;
  logic                    anyReq, pick, popEn;
  logic [CNT_W-1:0]        stallCnt, stallCntNext;
  logic [PACKET_WIDTH-1:0] headWord;

  // Scan starts just after the last winner so it is considered last.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int idx;
    winner = lastGrant;
    anyReq = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      idx = int'(lastGrant) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      cand = GIDX_W'(idx);
      if (!anyReq && bus.i_fifoHasPacket[cand]) begin
        anyReq = 1'b1;
        winner = cand;
      end
    end
  end

  assign pick     = (state == IDLE) || bus.i_arbiterReady;
  assign popEn    = pick && anyReq && !i_arst;
  assign headWord = bus.i_fifoReadData[winner];

  always_comb begin
    bus.o_fifoReadEn = '0;
    if (popEn) bus.o_fifoReadEn[winner] = 1'b1;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (anyReq) stateNext = HOLD;
      HOLD: if (bus.i_arbiterReady && !anyReq) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Only an unaccepted hold advances the counter; pops, IDLE and the drain to IDLE clear it.
  always_comb begin
    stallCntNext = '0;
    if (state == HOLD && !bus.i_arbiterReady)
      stallCntNext = (stallCnt == CNT_W'(STALL_LIMIT)) ? stallCnt : stallCnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state         <= IDLE;
      stallCnt      <= '0;
      bus.o_stalled <= 1'b0;
    end else begin
      state         <= stateNext;
      stallCnt      <= stallCntNext;
      bus.o_stalled <= (stallCntNext == CNT_W'(STALL_LIMIT));
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      bus.o_packet        <= '0;
      bus.o_packetIsValid <= 1'b0;
      bus.o_grantIdx      <= '0;
      lastGrant           <= GIDX_W'(NUM_INPUTS - 1);
    end else if (popEn) begin
      bus.o_packet        <= headWord;
      bus.o_packetIsValid <= 1'b1;
      bus.o_grantIdx      <= winner;
      lastGrant           <= winner;
    end else if (pick) begin
      bus.o_packetIsValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_input_arbiter.sv
// Directed bench for rr_input_arbiter: reset, single grant, rotation, sole requester,
// stall flag and reset during HOLD, with hand-computed expectations.
module tb_rr_input_arbiter;
  localparam int N  = 5;
  localparam int PW = 16;

  logic i_clk;
  logic i_arst;
  int   checks = 0;
  int   errors = 0;
  logic [PW-1:0] dataVal [N];

  rr_input_arbiter_if #(.NUM_INPUTS(N), .PACKET_WIDTH(PW)) bus ();

  rr_input_arbiter #(.NUM_INPUTS(N), .PACKET_WIDTH(PW), .STALL_LIMIT(4)) dut (
    .i_clk (i_clk),
    .i_arst(i_arst),
    .bus   (bus.master)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) dataVal[i] = 16'(16'h1000 + i);
    dataVal[2] = 16'hA5C3;
    for (int i = 0; i < N; i++) bus.i_fifoReadData[i] = dataVal[i];

    // Reset with every FIFO requesting
    i_arst = 1'b1;
    bus.i_fifoHasPacket = '1;
    bus.i_arbiterReady  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_readEn",   32'(bus.o_fifoReadEn),    32'h0);
    check("rst_valid",    32'(bus.o_packetIsValid), 32'h0);
    check("rst_packet",   32'(bus.o_packet),        32'h0);
    check("rst_grantIdx", 32'(bus.o_grantIdx),      32'h0);
    check("rst_stalled",  32'(bus.o_stalled),       32'h0);
    bus.i_fifoHasPacket = '0;
    #1 i_arst = 1'b0;
    tick();
    check("idle_valid", 32'(bus.o_packetIsValid), 32'h0);

    // Single requester, held until ready
    bus.i_fifoHasPacket = 5'b00100;
    #1 check("single_readEn", 32'(bus.o_fifoReadEn), 32'h4);
    tick();
    check("single_packet", 32'(bus.o_packet),        32'hA5C3);
    check("single_grant",  32'(bus.o_grantIdx),      32'h2);
    check("single_valid",  32'(bus.o_packetIsValid), 32'h1);
    bus.i_fifoHasPacket = '0;
    #1 check("single_noPop", 32'(bus.o_fifoReadEn), 32'h0);
    tick();
    tick();
    check("hold_packet",  32'(bus.o_packet),        32'hA5C3);
    check("hold_valid",   32'(bus.o_packetIsValid), 32'h1);
    check("hold_stalled", 32'(bus.o_stalled),       32'h0);
    bus.i_arbiterReady = 1'b1;
    tick();
    check("drain_valid",   32'(bus.o_packetIsValid), 32'h0);
    check("drain_stalled", 32'(bus.o_stalled),       32'h0);

    // Rotation: last grant was 2, so order is 3,4,0,1,2,3,4 with one pop per cycle
    bus.i_fifoHasPacket = '1;
    #1 check("rot_readEn0", 32'(bus.o_fifoReadEn), 32'h8);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("rot_grant",  32'(bus.o_grantIdx),      32'((3 + k) % N));
      check("rot_packet", 32'(bus.o_packet),        32'(dataVal[(3 + k) % N]));
      check("rot_valid",  32'(bus.o_packetIsValid), 32'h1);
      check("rot_readEn", 32'(bus.o_fifoReadEn),    32'(1 << ((4 + k) % N)));
    end

    // Sole requester wins back-to-back; newcomer at 1 is next after wrap
    bus.i_fifoHasPacket = 5'b01000;
    #1 check("sole_readEn0", 32'(bus.o_fifoReadEn), 32'h8);
    repeat (3) begin
      tick();
      check("sole_grant",  32'(bus.o_grantIdx),   32'h3);
      check("sole_readEn", 32'(bus.o_fifoReadEn), 32'h8);
    end
    bus.i_fifoHasPacket = 5'b01010;
    #1 check("join_readEn", 32'(bus.o_fifoReadEn), 32'h2);
    tick();
    check("join_grant",  32'(bus.o_grantIdx), 32'h1);
    check("join_packet", 32'(bus.o_packet),   32'(dataVal[1]));
    bus.i_fifoHasPacket = '0;
    #1 check("empty_readEn", 32'(bus.o_fifoReadEn), 32'h0);
    tick();
    check("empty_valid", 32'(bus.o_packetIsValid), 32'h0);

    // Stall flag with STALL_LIMIT=4
    bus.i_fifoHasPacket = 5'b00001;
    bus.i_arbiterReady  = 1'b0;
    #1 check("stall_readEn", 32'(bus.o_fifoReadEn), 32'h1);
    tick();
    check("stall_grant", 32'(bus.o_grantIdx),      32'h0);
    check("stall_valid", 32'(bus.o_packetIsValid), 32'h1);
    bus.i_fifoHasPacket = '0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("stall_flag", 32'(bus.o_stalled), (c >= 4) ? 32'h1 : 32'h0);
    end
    check("stall_packet", 32'(bus.o_packet), 32'(dataVal[0]));
    bus.i_arbiterReady = 1'b1;
    tick();
    check("stall_clear", 32'(bus.o_stalled),       32'h0);
    check("stall_idle",  32'(bus.o_packetIsValid), 32'h0);

    // Reset mid-HOLD: held packet dropped, no pop, scan restarts at 0
    bus.i_arbiterReady  = 1'b0;
    bus.i_fifoHasPacket = 5'b00100;
    #1 check("pre_readEn", 32'(bus.o_fifoReadEn), 32'h4);
    tick();
    check("pre_grant", 32'(bus.o_grantIdx),      32'h2);
    check("pre_valid", 32'(bus.o_packetIsValid), 32'h1);
    bus.i_fifoHasPacket = 5'b01101;
    #1 check("pre_noPop", 32'(bus.o_fifoReadEn), 32'h0);
    #1 i_arst = 1'b1;
    #1;
    check("mid_valid",  32'(bus.o_packetIsValid), 32'h0);
    check("mid_packet", 32'(bus.o_packet),        32'h0);
    check("mid_readEn", 32'(bus.o_fifoReadEn),    32'h0);
    check("mid_grant",  32'(bus.o_grantIdx),      32'h0);
    #1 i_arst = 1'b0;
    #1 check("post_readEn", 32'(bus.o_fifoReadEn), 32'h1);
    tick();
    check("post_grant",  32'(bus.o_grantIdx),      32'h0);
    check("post_packet", 32'(bus.o_packet),        32'(dataVal[0]));
    check("post_valid",  32'(bus.o_packetIsValid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
